// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
// Bit-serial magnitude comparator. Operands are captured on an accepted start
// and scanned one bit pair per clock, MSB first. In signed mode the MSB is
// read as the sign bit. The first (highest) differing bit decides the result.
// With EARLY_EXIT=1 the scan stops at that bit. With EARLY_EXIT=0 it always
// runs down to bit 0, so the latency is fixed.
`timescale 1ns/1ps
module serial_mag_comparator #(
   parameter int WIDTH      = 8,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic             busy,
   output logic             done,
   output logic             smaller,
   output logic             equal,
   output logic             greater
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_signed;
   logic [IDX_W-1:0] r_idx;
   logic             r_found;      // a differing bit has already been seen
   logic             r_found_gt;   // result decided by that bit: 1 = A greater
   logic             r_done;
   logic             r_smaller;
   logic             r_equal;
   logic             r_greater;

   logic             w_bit_a;
   logic             w_bit_b;
   logic             w_diff;
   logic             w_is_msb;
   logic             w_last_bit;
   logic             w_a_wins;
   logic             w_accept;
   logic             w_terminate;

   // Bit pair currently under evaluation and how it would decide the result.
   assign w_bit_a    = r_a[r_idx];
   assign w_bit_b    = r_b[r_idx];
   assign w_diff     = w_bit_a ^ w_bit_b;
   assign w_is_msb   = (r_idx == MSB_IDX);
   assign w_last_bit = (r_idx == '0);
   // A sign bit of 1 means A is negative, which inverts the meaning of the MSB.
   assign w_a_wins   = (w_is_msb && r_signed) ? ~w_bit_a : w_bit_a;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so that every
         // register samples pre-edge values regardless of statement order.
         r_state <= w_state_next;
      end
   end

   // Next-state decode: accept start in IDLE, finish on the terminating bit.
   always_comb begin
      // NOTE: defaults first so that no path leaves a signal unassigned, which
      // would otherwise infer a latch.
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_terminate  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = SCAN;
            end
         end
         SCAN: begin
            if (w_last_bit || ((EARLY_EXIT != 0) && w_diff)) begin
               w_terminate  = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Operand capture, bit scanning and the registered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the captured operands and the index are reset along with the
         // control state, so nothing left over from an aborted scan is visible.
         r_a        <= '0;
         r_b        <= '0;
         r_signed   <= 1'b0;
         r_idx      <= '0;
         r_found    <= 1'b0;
         r_found_gt <= 1'b0;
         r_done     <= 1'b0;
         r_smaller  <= 1'b0;
         r_equal    <= 1'b0;
         r_greater  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a        <= a;
            r_b        <= b;
            r_signed   <= is_signed;
            r_idx      <= MSB_IDX;
            r_found    <= 1'b0;
            r_found_gt <= 1'b0;
         end else if (r_state == SCAN) begin
            // Only the first differing bit is remembered; lower bits cannot override it.
            if (w_diff && !r_found) begin
               r_found    <= 1'b1;
               r_found_gt <= w_a_wins;
            end
            if (w_terminate) begin
               r_done <= 1'b1;
               if (r_found) begin
                  r_smaller <= ~r_found_gt;
                  r_equal   <= 1'b0;
                  r_greater <= r_found_gt;
               end else if (w_diff) begin
                  r_smaller <= ~w_a_wins;
                  r_equal   <= 1'b0;
                  r_greater <= w_a_wins;
               end else begin
                  r_smaller <= 1'b0;
                  r_equal   <= 1'b1;
                  r_greater <= 1'b0;
               end
            end else begin
               r_idx <= r_idx - IDX_W'(1);
            end
         end
      end
   end

   assign busy    = (r_state == SCAN);
   assign done    = r_done;
   assign smaller = r_smaller;
   assign equal   = r_equal;
   assign greater = r_greater;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb_serial_mag_comparator
// Three instances share one clock and one reset:
//   dut 0: WIDTH=8, EARLY_EXIT=1
//   dut 1: WIDTH=8, EARLY_EXIT=0
//   dut 2: WIDTH=1, EARLY_EXIT=1
// Expected results and latencies come from an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_mag_comparator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_v [3];
   logic [7:0] a_v [3];
   logic [7:0] b_v [3];
   logic       sgn_v [3];
   logic [2:0] busy_v, done_v, sm_v, eq_v, gt_v;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1)) u_dut_ee (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
      .is_signed(sgn_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .smaller(sm_v[0]), .equal(eq_v[0]), .greater(gt_v[0]));

   serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(0)) u_dut_full (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
      .is_signed(sgn_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .smaller(sm_v[1]), .equal(eq_v[1]), .greater(gt_v[1]));

   serial_mag_comparator #(.WIDTH(1), .EARLY_EXIT(1)) u_dut_w1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2][0:0]), .b(b_v[2][0:0]),
      .is_signed(sgn_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .smaller(sm_v[2]), .equal(eq_v[2]), .greater(gt_v[2]));

   // Result encoding used throughout: {smaller, equal, greater}
   localparam logic [2:0] R_LT = 3'b100;
   localparam logic [2:0] R_EQ = 3'b010;
   localparam logic [2:0] R_GT = 3'b001;

   function automatic logic [2:0] get_res(input int sel);
      return {sm_v[sel], eq_v[sel], gt_v[sel]};
   endfunction

   // Reference model: numeric compare plus latency from the highest differing bit.
   function automatic void model(input int sel, input logic [7:0] a, input logic [7:0] b,
                                 input logic sgn, output logic [2:0] res, output int k);
      int     w;
      bit     ee;
      longint ma, mb;
      int     hi;
      w  = (sel == 2) ? 1 : 8;
      ee = (sel != 1);
      ma = longint'(a) & ((64'sd1 << w) - 1);
      mb = longint'(b) & ((64'sd1 << w) - 1);
      if (sgn && ma[w-1]) ma = ma - (64'sd1 << w);
      if (sgn && mb[w-1]) mb = mb - (64'sd1 << w);
      res = (ma < mb) ? R_LT : (ma == mb) ? R_EQ : R_GT;
      hi = -1;
      for (int i = 0; i < w; i++) if (a[i] != b[i]) hi = i;
      k = (ee && hi >= 0) ? (w - hi) : w;
   endfunction

   // Drive start at the current time, let edge E0 take it, then scramble the
   // operand inputs so any late sampling would corrupt the result.
   task automatic launch(input int sel, input logic [7:0] a, input logic [7:0] b, input logic sgn);
      start_v[sel] = 1'b1;
      a_v[sel]     = a;
      b_v[sel]     = b;
      sgn_v[sel]   = sgn;
      @(posedge clk);
      #1;
      start_v[sel] = 1'b0;
      a_v[sel]     = 8'($urandom);
      b_v[sel]     = 8'($urandom);
      sgn_v[sel]   = 1'($urandom);
   endtask

   task automatic start_cmp(input int sel, input logic [7:0] a, input logic [7:0] b, input logic sgn);
      @(negedge clk);
      launch(sel, a, b, sgn);
   endtask

   // Called at E0+1; returns at Ek+1 (or Ek+1 plus one cycle when chk_pulse is set).
   task automatic wait_done(input int sel, input logic [2:0] exp_res, input int exp_k,
                            input string name, input bit chk_pulse, input int drop_at);
      int k, bcnt;
      bit got;
      k = 0; bcnt = 0; got = 0;
      if (busy_v[sel]) bcnt++;
      while (!got && k < 200) begin
         @(posedge clk);
         #1;
         k++;
         if (k == drop_at) start_v[sel] = 1'b0;
         if (done_v[sel]) got = 1;
         else if (busy_v[sel]) bcnt++;
      end
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s timeout: no done within %0d cycles", name, k);
         return;
      end
      if (k !== exp_k) begin
         n_fail++;
         $display("FAIL %s latency: got %0d expected %0d", name, k, exp_k);
      end
      n_tests++;
      if (bcnt !== exp_k || busy_v[sel] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s busy: cycles %0d (busy now %b) expected %0d (busy now 0)",
                  name, bcnt, busy_v[sel], exp_k);
      end
      n_tests++;
      if (get_res(sel) !== exp_res) begin
         n_fail++;
         $display("FAIL %s result: got %b expected %b", name, get_res(sel), exp_res);
      end
      if (chk_pulse) begin
         @(posedge clk);
         #1;
         n_tests++;
         if (done_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0 || get_res(sel) !== exp_res) begin
            n_fail++;
            $display("FAIL %s after_done: done=%b busy=%b res=%b expected 0 0 %b",
                     name, done_v[sel], busy_v[sel], get_res(sel), exp_res);
         end
      end
   endtask

   task automatic run_exp(input int sel, input logic [7:0] a, input logic [7:0] b, input logic sgn,
                          input logic [2:0] exp_res, input int exp_k, input string name);
      start_cmp(sel, a, b, sgn);
      wait_done(sel, exp_res, exp_k, name, 1'b1, 0);
   endtask

   task automatic check_idle_zero(input string name);
      for (int s = 0; s < 3; s++) begin
         n_tests++;
         if ({busy_v[s], done_v[s], get_res(s)} !== 5'b0) begin
            n_fail++;
            $display("FAIL %s dut%0d: busy/done/res=%b expected 00000",
                     name, s, {busy_v[s], done_v[s], get_res(s)});
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      check_idle_zero("reset_asserted");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle_zero("after_reset_idle");
   endtask

   task automatic test_directed();
      run_exp(0, 8'h80, 8'h7F, 1'b0, R_GT, 1, "ee_unsigned_80_7f");
      run_exp(0, 8'h80, 8'h7F, 1'b1, R_LT, 1, "ee_signed_80_7f");
      run_exp(0, 8'h5A, 8'h5A, 1'b0, R_EQ, 8, "ee_equal_5a");
      run_exp(1, 8'h5A, 8'h5A, 1'b1, R_EQ, 8, "full_equal_5a");
      run_exp(0, 8'h03, 8'h02, 1'b0, R_GT, 8, "ee_03_02");
      run_exp(1, 8'h80, 8'h7F, 1'b0, R_GT, 8, "full_unsigned_80_7f");
      run_exp(1, 8'h80, 8'h7F, 1'b1, R_LT, 8, "full_signed_80_7f");
      run_exp(0, 8'hFF, 8'h01, 1'b1, R_LT, 1, "ee_signed_m1_1");
      run_exp(0, 8'h10, 8'h20, 1'b0, R_LT, 3, "ee_10_20");
      run_exp(1, 8'hF0, 8'hE7, 1'b1, R_GT, 8, "full_signed_lower_bits");
   endtask

   task automatic test_random();
      logic [7:0] a, b;
      logic       sgn;
      logic [2:0] res;
      int         k, p;
      for (int sel = 0; sel < 2; sel++) begin
         for (int n = 0; n < 40; n++) begin
            a   = 8'($urandom);
            sgn = 1'($urandom);
            case (n % 4)
               0: b = 8'($urandom);
               1: b = a;
               default: begin
                  // Share a random-length prefix so the first difference lands anywhere.
                  p = $urandom_range(7, 0);
                  b = a ^ (8'd1 << p) ^ (8'($urandom) & ((8'd1 << p) - 8'd1));
               end
            endcase
            model(sel, a, b, sgn, res, k);
            start_cmp(sel, a, b, sgn);
            wait_done(sel, res, k, $sformatf("rand_dut%0d_%02h_%02h_s%0d", sel, a, b, sgn), n % 8 == 0, 0);
         end
      end
   endtask

   task automatic test_width1();
      logic [2:0] res;
      for (int i = 0; i < 8; i++) begin
         logic a1, b1, s1;
         a1 = i[2]; b1 = i[1]; s1 = i[0];
         // Unsigned: plain 1-bit magnitude. Signed: 1 is -1, so 1 < 0.
         if (a1 == b1)      res = R_EQ;
         else if (s1)       res = (a1 == 1'b0) ? R_GT : R_LT;
         else               res = (a1 == 1'b1) ? R_GT : R_LT;
         run_exp(2, {7'd0, a1}, {7'd0, b1}, s1, res, 1,
                 $sformatf("w1_a%0d_b%0d_s%0d", a1, b1, s1));
      end
   endtask

   task automatic test_ignore_busy();
      start_cmp(1, 8'h03, 8'h02, 1'b0);
      // A competing request with different operands, held for three edges.
      start_v[1] = 1'b1;
      a_v[1]     = 8'h01;
      b_v[1]     = 8'h90;
      sgn_v[1]   = 1'b1;
      wait_done(1, R_GT, 8, "ignore_start_while_busy", 1'b1, 3);
   endtask

   task automatic test_hold();
      run_exp(0, 8'h80, 8'h7F, 1'b0, R_GT, 1, "hold_setup");
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (get_res(0) !== R_GT) begin
         n_fail++;
         $display("FAIL hold_idle: got %b expected %b", get_res(0), R_GT);
      end
      start_cmp(0, 8'h5A, 8'h5A, 1'b0);
      n_tests++;
      if (get_res(0) !== R_GT || busy_v[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_scan: res=%b busy=%b expected %b 1", get_res(0), busy_v[0], R_GT);
      end
      wait_done(0, R_EQ, 8, "hold_then_equal", 1'b1, 0);
   endtask

   task automatic test_back_to_back();
      start_cmp(0, 8'h80, 8'h7F, 1'b0);
      wait_done(0, R_GT, 1, "b2b_first", 1'b0, 0);
      // Now at Ek+1 with done high: request the next compare in this cycle.
      launch(0, 8'h01, 8'h02, 1'b0);
      n_tests++;
      if (busy_v[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept: busy=%b expected 1", busy_v[0]);
      end
      wait_done(0, R_LT, 7, "b2b_second", 1'b1, 0);
   endtask

   task automatic test_reset_mid_scan();
      int seen_done;
      start_cmp(1, 8'h5A, 8'h5A, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_idle_zero("reset_mid_scan");
      seen_done = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done_v[1]) seen_done++;
      end
      n_tests++;
      if (seen_done !== 0) begin
         n_fail++;
         $display("FAIL reset_no_done: done seen %0d times expected 0", seen_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      launch(1, 8'h12, 8'h34, 1'b0);
      wait_done(1, R_LT, 8, "after_reset_compare", 1'b1, 0);
   endtask

   initial begin
      for (int s = 0; s < 3; s++) begin
         start_v[s] = 1'b0;
         a_v[s]     = 8'h00;
         b_v[s]     = 8'h00;
         sgn_v[s]   = 1'b0;
      end
      test_reset();
      test_directed();
      test_width1();
      test_ignore_busy();
      test_hold();
      test_back_to_back();
      test_random();
      test_reset_mid_scan();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
